// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared state encodings, opcodes and instruction field positions
package control_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_t;

  typedef enum logic [1:0] {LD_IDLE, LD_MEM, LD_WB} load_state_t;

  localparam logic [2:0] CLS_SYS = 3'd0;
  localparam logic [2:0] CLS_ALU = 3'd1;
  localparam logic [2:0] CLS_MEM = 3'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_MV  = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  localparam logic [2:0] OP_SDW = 3'd0;
  localparam logic [2:0] OP_LDW = 3'd3;
  localparam logic [2:0] OP_HLT = 3'd7;

  localparam int CLS_LSB = 29;
  localparam int OP_LSB  = 24;
  localparam int FA_LSB  = 20;
  localparam int FB_LSB  = 16;
  localparam int I_BIT   = 15;
  localparam int RS2_LSB = 11;

  function automatic logic [31:0] sext11(input logic [10:0] v);
    return {{21{v[10]}}, v};
  endfunction

  function automatic logic [31:0] sext15(input logic [14:0] v);
    return {{17{v[14]}}, v};
  endfunction
endpackage

// File: rtl/byte_mem.sv
// rtl/byte_mem.sv - byte-wide memory with a big-endian word read and word write port
module byte_mem #(
  parameter int MEM_BYTES = 4096
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_BYTES)-1:0] addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);
  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0]    memory_bank [0:MEM_BYTES-1];
  logic [AW-1:0] a1, a2, a3;

  assign a1 = addr + AW'(1);
  assign a2 = addr + AW'(2);
  assign a3 = addr + AW'(3);
  assign rdata = {memory_bank[addr], memory_bank[a1], memory_bank[a2], memory_bank[a3]};

  always_ff @(posedge clk) begin
    if (we) begin
      memory_bank[addr] <= wdata[31:24];
      memory_bank[a1]   <= wdata[23:16];
      memory_bank[a2]   <= wdata[15:8];
      memory_bank[a3]   <= wdata[7:0];
    end
  end
endmodule

// File: rtl/control_ld_seq.sv
// rtl/control_ld_seq.sv - load sequencing: captures load data in MEM and flags that cycle
module control_ld_seq
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        start,
  input  logic [31:0] rdata,
  output logic        ld_done,
  output logic [31:0] y_data
);
  load_state_t load_state, load_state_d;
  logic [31:0] y_data_d;

  always_comb begin
    load_state_d = load_state;
    y_data_d     = y_data;
    case (load_state)
      LD_IDLE: if (start) load_state_d = LD_MEM;
      LD_MEM: begin
        load_state_d = LD_WB;
        y_data_d     = rdata;
      end
      LD_WB:   load_state_d = LD_IDLE;
      default: load_state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_state <= LD_IDLE;
      y_data     <= '0;
    end else if (enable) begin
      load_state <= load_state_d;
      y_data     <= y_data_d;
    end
  end

  assign ld_done = (load_state == LD_MEM);
endmodule

// File: rtl/control_regfile.sv
// rtl/control_regfile.sv - 16x32 register file, two read ports, register 0 hard-wired to zero
module control_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  wa,
  input  logic [3:0]  ra1,
  input  logic [3:0]  ra2,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [0:15];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) regs[k] <= '0;
    end else if (we && wa != 4'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
endmodule

// File: rtl/control.sv
// rtl/control.sv - multi-cycle core: fetch, decode, execute, memory and writeback sequencing
module control
  import control_pkg::*;
#(
  parameter int MEM_BYTES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic halted
);
  localparam int AW = $clog2(MEM_BYTES);

  state_t        fsm_state, fsm_state_d;
  logic [AW-1:0] pc_q, ea_q, ea;
  logic [31:0]   ir_q, a_q, b_q, y_q, y, y_data, instr, dmem_rdata, rd1, rd2, op2, ea_full, wd;
  logic [2:0]    cls, op;
  logic [3:0]    i1, i2, id, x1, x2, xd;
  logic          imm_sel, is_alu, is_store, is_load, is_hlt, wen_regs, ld_done, dmem_we;
  logic          unused_bits;

  assign cls      = ir_q[CLS_LSB +: 3];
  assign op       = ir_q[OP_LSB +: 3];
  assign id       = ir_q[FA_LSB +: 4];
  assign i1       = ir_q[FB_LSB +: 4];
  assign i2       = ir_q[RS2_LSB +: 4];
  assign imm_sel  = ir_q[I_BIT];
  assign is_alu   = (cls == CLS_ALU);
  assign is_store = (cls == CLS_MEM) && (op == OP_SDW);
  assign is_load  = (cls == CLS_MEM) && (op == OP_LDW);
  assign is_hlt   = (cls == CLS_SYS) && (op == OP_HLT);

  // Stores use fa as the base and fb as data, so the read ports swap for them.
  assign x1 = is_store ? id : i1;
  assign x2 = is_store ? i1 : i2;
  assign xd = id;

  always_comb begin
    op2 = imm_sel ? sext11(ir_q[10:0]) : b_q;
    y   = '0;
    case (op)
      OP_ADD: y = a_q + op2;
      OP_MV:  y = op2;
      OP_SUB: y = a_q - op2;
      OP_AND: y = a_q & op2;
      OP_OR:  y = a_q | op2;
      OP_XOR: y = a_q ^ op2;
      OP_SHL: y = a_q << op2[4:0];
      OP_SHR: y = a_q >> op2[4:0];
      default: y = '0;
    endcase
  end

  assign ea_full     = a_q + sext15(ir_q[14:0]);
  assign ea          = ea_full[AW-1:0] & {{(AW-2){1'b1}}, 2'b00};
  assign unused_bits = ^{ir_q[28:27], ea_full[31:AW]};

  always_comb begin
    fsm_state_d = fsm_state;
    case (fsm_state)
      S_IDLE:    fsm_state_d = S_FETCH;
      S_FETCH:   fsm_state_d = S_DECODE;
      S_DECODE:  fsm_state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (is_load || is_store) fsm_state_d = S_MEM;
        else if (is_alu)         fsm_state_d = S_WRITEBACK;
        else if (is_hlt)         fsm_state_d = S_HALT;
        else                     fsm_state_d = S_FETCH;
      end
      S_MEM:       fsm_state_d = is_load ? S_WRITEBACK : S_FETCH;
      S_WRITEBACK: fsm_state_d = S_FETCH;
      S_HALT:      fsm_state_d = S_HALT;
      default:     fsm_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_state <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      y_q       <= '0;
      ea_q      <= '0;
      wen_regs  <= 1'b0;
      halted    <= 1'b0;
    end else if (enable) begin
      fsm_state <= fsm_state_d;
      wen_regs  <= (fsm_state_d == S_WRITEBACK);
      halted    <= (fsm_state_d == S_HALT);
      case (fsm_state)
        S_FETCH:  ir_q <= instr;
        S_DECODE: begin
          a_q <= rd1;
          b_q <= rd2;
        end
        S_EXECUTE: begin
          y_q  <= y;
          ea_q <= ea;
          if (!is_hlt) pc_q <= pc_q + AW'(4);
        end
        default: ;
      endcase
    end
  end

  assign wd      = is_load ? y_data : y_q;
  assign dmem_we = (fsm_state == S_MEM) && is_store && enable;

  byte_mem #(.MEM_BYTES(MEM_BYTES)) instr_cache (
    .clk(clk), .we(1'b0), .addr(pc_q), .wdata(32'd0), .rdata(instr)
  );

  byte_mem #(.MEM_BYTES(MEM_BYTES)) data_cache (
    .clk(clk), .we(dmem_we), .addr(ea_q), .wdata(b_q), .rdata(dmem_rdata)
  );

  control_regfile r (
    .clk(clk), .rst(rst), .we(wen_regs && enable), .wa(xd), .ra1(x1), .ra2(x2),
    .wd(wd), .rd1(rd1), .rd2(rd2)
  );

  control_ld_seq dt (
    .clk(clk), .rst(rst), .enable(enable), .start((fsm_state == S_EXECUTE) && is_load),
    .rdata(dmem_rdata), .ld_done(ld_done), .y_data(y_data)
  );
endmodule

// File: tb/tb_control.sv
// tb/tb_control.sv - directed and randomized checks of control against an instruction-level model
module tb_control;
  import control_pkg::*;

  localparam int MEM = 4096;
  localparam logic [31:0] HLT = 32'h0700_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic halted;

  control #(.MEM_BYTES(MEM)) dut (.clk(clk), .rst(rst), .enable(enable), .halted(halted));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0]  m_imem [MEM];
  logic [7:0]  m_dmem [MEM];
  logic [31:0] m_regs [16];
  int m_pc, next_fetch, halt_cycle, ld_cycle, en_cycles;
  bit last_en, model_on;
  state_t prev_state;
  logic [31:0] prog [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int op, input int fa, input int fb, input int imm);
    return {3'd1, 2'b00, 3'(op), 4'(fa), 4'(fb), 1'b1, 4'd0, 11'(imm)};
  endfunction

  function automatic logic [31:0] enc_r(input int op, input int fa, input int fb, input int rs2);
    return {3'd1, 2'b00, 3'(op), 4'(fa), 4'(fb), 1'b0, 4'(rs2), 11'd0};
  endfunction

  function automatic logic [31:0] enc_m(input int op, input int fa, input int fb, input int imm);
    return {3'd2, 2'b00, 3'(op), 4'(fa), 4'(fb), 1'b0, 15'(imm)};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 5) w[31:29] = 3'd1;
    else if (k < 8) begin
      w[31:29] = 3'd2;
      if ($urandom_range(0, 3) == 0) w[26:24] = 3'($urandom_range(0, 7));
      else w[26:24] = ($urandom_range(0, 1) == 1) ? 3'd3 : 3'd0;
    end else if (k < 9) begin
      w[31:29] = 3'd0;
      w[26:24] = 3'($urandom_range(0, 6));
    end else w[31:29] = 3'($urandom_range(3, 7));
    return w;
  endfunction

  function automatic logic [31:0] dut_word(input int a);
    return {dut.data_cache.memory_bank[a], dut.data_cache.memory_bank[a+1],
            dut.data_cache.memory_bank[a+2], dut.data_cache.memory_bank[a+3]};
  endfunction

  // Architectural interpreter: one whole instruction per call, plus its cycle cost.
  task automatic model_step();
    logic [31:0] w, a, o2, r, off;
    logic [2:0] cls, op;
    logic [3:0] fa, fb, rs2;
    int ea, lat;
    w   = {m_imem[m_pc], m_imem[m_pc+1], m_imem[m_pc+2], m_imem[m_pc+3]};
    cls = w[31:29]; op = w[26:24]; fa = w[23:20]; fb = w[19:16]; rs2 = w[14:11];
    off = {{17{w[14]}}, w[14:0]};
    lat = 3;
    if (cls == 3'd1) begin
      a  = m_regs[fb];
      o2 = w[15] ? {{21{w[10]}}, w[10:0]} : m_regs[rs2];
      case (op)
        3'd0: r = a + o2;
        3'd1: r = o2;
        3'd2: r = a - o2;
        3'd3: r = a & o2;
        3'd4: r = a | o2;
        3'd5: r = a ^ o2;
        3'd6: r = a << o2[4:0];
        default: r = a >> o2[4:0];
      endcase
      if (fa != 0) m_regs[fa] = r;
      lat = 4;
    end else if (cls == 3'd2 && op == 3'd0) begin
      ea = int'((m_regs[fa] + off) % MEM) & ~3;
      for (int b = 0; b < 4; b++) m_dmem[ea+b] = m_regs[fb][31-8*b -: 8];
      lat = 4;
    end else if (cls == 3'd2 && op == 3'd3) begin
      ea = int'((m_regs[fb] + off) % MEM) & ~3;
      r  = {m_dmem[ea], m_dmem[ea+1], m_dmem[ea+2], m_dmem[ea+3]};
      if (fa != 0) m_regs[fa] = r;
      ld_cycle = next_fetch + 3;
      lat = 5;
    end else if (cls == 3'd0 && op == 3'd7) begin
      halt_cycle = next_fetch + 3;
      next_fetch = -1;
      return;
    end
    m_pc = (m_pc + 4) % MEM;
    next_fetch = next_fetch + lat;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      en_cycles = 0;
      last_en   = 1'b0;
    end else begin
      last_en = enable;
      if (enable) en_cycles++;
    end
  end

  always @(negedge clk) begin
    int nbad;
    if (model_on && !rst) begin
      chk("halted", 32'(halted), 32'(halt_cycle != 0 && en_cycles >= halt_cycle));
      chk("ld_done", 32'(dut.ld_done), 32'(ld_cycle != 0 && en_cycles == ld_cycle));
      if (!last_en) chk("freeze_state", 32'(dut.fsm_state), 32'(prev_state));
      if (en_cycles == next_fetch) begin
        chk("fetch_state", 32'(dut.fsm_state), 32'(S_FETCH));
        chk("fetch_pc", 32'(dut.pc_q), 32'(m_pc));
        nbad = 0;
        for (int k = 0; k < 16; k++) if (dut.r.regs[k] !== m_regs[k]) nbad++;
        chk("fetch_regs_mismatch", 32'(nbad), 32'd0);
        model_step();
      end
    end
    prev_state = dut.fsm_state;
  end

  task automatic load_and_start(input bit rand_dmem);
    logic [7:0] v;
    logic [31:0] w;
    model_on = 1'b0;
    rst = 1'b1;
    enable = 1'b0;
    for (int a = 0; a < MEM; a++) begin
      v = rand_dmem ? 8'($urandom) : 8'h00;
      m_dmem[a] = v;
      dut.data_cache.memory_bank[a] = v;
      m_imem[a] = 8'h00;
      dut.instr_cache.memory_bank[a] = 8'h00;
    end
    for (int n = 0; n < prog.size(); n++) begin
      w = prog[n];
      for (int b = 0; b < 4; b++) begin
        m_imem[4*n+b] = w[31-8*b -: 8];
        dut.instr_cache.memory_bank[4*n+b] = w[31-8*b -: 8];
      end
    end
    for (int k = 0; k < 16; k++) m_regs[k] = '0;
    m_pc = 0; next_fetch = 1; halt_cycle = 0; ld_cycle = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_on = 1'b1;
    enable = 1'b1;
  endtask

  task automatic run_to_halt(input bit rand_en, input int freeze_at);
    int cyc, nbad;
    state_t s;
    cyc = 0;
    while (!halted && cyc < 8000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == freeze_at) begin
        s = dut.fsm_state;
        enable = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("freeze_10_cycles", 32'(dut.fsm_state), 32'(s));
        enable = 1'b1;
      end else if (rand_en) enable = ($urandom_range(0, 7) != 0);
    end
    chk("halt_reached", 32'(halted), 32'd1);
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("final_pc", 32'(dut.pc_q), 32'(m_pc));
    nbad = 0;
    for (int k = 0; k < 16; k++) if (dut.r.regs[k] !== m_regs[k]) nbad++;
    chk("final_regs_mismatch", 32'(nbad), 32'd0);
    nbad = 0;
    for (int a = 0; a < MEM; a++) if (dut.data_cache.memory_bank[a] !== m_dmem[a]) nbad++;
    chk("final_dmem_mismatch", 32'(nbad), 32'd0);
  endtask

  initial begin
    int nbad;
    logic [31:0] orig;
    model_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(dut.fsm_state), 32'(S_IDLE));
    chk("rst_pc", 32'(dut.pc_q), 32'd0);
    chk("rst_wen_regs", 32'(dut.wen_regs), 32'd0);
    chk("rst_ld_done", 32'(dut.ld_done), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    nbad = 0;
    for (int k = 0; k < 16; k++) if (dut.r.regs[k] !== 32'd0) nbad++;
    chk("rst_regs_nonzero", 32'(nbad), 32'd0);

    // Store/load program, run straight through and then with a 10-cycle enable drop.
    for (int pass = 0; pass < 2; pass++) begin
      prog = '{enc_i(OP_MV, 5, 0, 10), enc_m(OP_SDW, 0, 5, 4), enc_i(OP_MV, 5, 0, 11),
               enc_m(OP_SDW, 0, 5, 8), enc_m(OP_LDW, 6, 0, 4), HLT};
      load_and_start(1'b1);
      run_to_halt(1'b0, (pass == 0) ? -1 : 7);
      chk("prog_mem4", dut_word(4), 32'd10);
      chk("prog_mem8", dut_word(8), 32'd11);
      chk("prog_r5", dut.r.regs[5], 32'd11);
      chk("prog_r6", dut.r.regs[6], 32'd10);
      chk("prog_halted", 32'(halted), 32'd1);
      chk("model_r6", m_regs[6], 32'd10);
    end

    prog = '{enc_i(OP_MV, 7, 0, 11'h7FF), enc_i(OP_MV, 0, 0, 10), HLT};
    load_and_start(1'b0);
    run_to_halt(1'b0, -1);
    chk("mv_neg1_r7", dut.r.regs[7], 32'hFFFF_FFFF);
    chk("mv_rzero_r0", dut.r.regs[0], 32'd0);

    // add is fetched on enabled cycle 9; its result must appear exactly at cycle 13.
    prog = '{enc_i(OP_MV, 5, 0, 5), enc_i(OP_MV, 6, 0, 7), enc_r(OP_ADD, 7, 5, 6), HLT};
    load_and_start(1'b0);
    for (int c = 0; c < 60 && en_cycles < 12; c++) @(negedge clk);
    chk("add_cycle12_r7", dut.r.regs[7], 32'd0);
    @(negedge clk);
    chk("add_cycle13_r7", dut.r.regs[7], 32'd12);
    run_to_halt(1'b0, -1);

    // Reset in the MEM cycle of a store discards the write.
    prog = '{enc_i(OP_MV, 5, 0, 77), enc_m(OP_SDW, 0, 5, 16), HLT};
    load_and_start(1'b1);
    orig = {m_dmem[16], m_dmem[17], m_dmem[18], m_dmem[19]};
    for (int c = 0; c < 60 && dut.fsm_state != S_MEM; c++) begin
      @(posedge clk); #1;
    end
    chk("abort_in_mem", 32'(dut.fsm_state), 32'(S_MEM));
    model_on = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_mem16", dut_word(16), orig);
    chk("abort_pc", 32'(dut.pc_q), 32'd0);
    chk("abort_state", 32'(dut.fsm_state), 32'(S_IDLE));

    for (int p = 0; p < 4; p++) begin
      prog.delete();
      for (int n = 0; n < 40; n++) prog.push_back(rand_instr());
      prog.push_back(HLT);
      load_and_start(1'b1);
      run_to_halt(1'b1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 Parameter MEM_BYTES, default 4096, is the size of each byte memory in bytes.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port enable, input, 1 bit: run enable; an X or 0 value is treated as not enabled.
REQ-005 Port halted, output, 1 bit: high while the FSM is in HALT.
REQ-006 The design has no other ports; the instruction and data memories load and inspect only through the hierarchy.

Function
REQ-007 Instruction word fields: cls=[31:29], fmt=[28:27] (ignored), op=[26:24], fa=[23:20], fb=[19:16], i=[15], rs2=[14:11], imm11=[10:0], imm15=[14:0].
REQ-008 Register file: 16 x 32 bits; reg 0 (rzero) reads 0 and ignores writes; gpr0..gpr10 map to regs 5..15.
REQ-009 ALU class (cls=1), destination fa: operand1=reg[fb]; operand2=sext(imm11) if i=1, otherwise reg[rs2].
REQ-010 ALU op encoding: 0 add, 1 mv (rd=operand2), 2 sub, 3 and, 4 or, 5 xor, 6 shl, 7 shr (logical); shift amount is operand2[4:0].
REQ-011 Memory class (cls=2), op 0 sdw: mem[reg[fa]+sext(imm15)] = reg[fb].
REQ-012 Memory class (cls=2), op 3 ldw: reg[fa] = mem[reg[fb]+sext(imm15)].
REQ-013 Memory class, all other ops: no operation.
REQ-014 System class (cls=0): op 7 = hlt; op 0 and every other op = nop.
REQ-015 Classes 3..7 execute as nop.
REQ-016 Memory byte order is big-endian: word = {bank[a], bank[a+1], bank[a+2], bank[a+3]}.
REQ-017 Effective addresses are taken modulo MEM_BYTES with bits [1:0] forced to 0.
REQ-018 PC is a byte address and advances by 4 after every non-halt instruction; it wraps at MEM_BYTES.
REQ-019 FSM states: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
REQ-020 FSM transitions:
- IDLE -> FETCH when enable=1.
- FETCH -> DECODE.
- DECODE -> EXECUTE.
- EXECUTE -> MEM for a load or store.
- EXECUTE -> WRITEBACK for an ALU instruction.
- EXECUTE -> HALT for hlt.
- EXECUTE -> FETCH for a nop.
- MEM -> WRITEBACK for a load.
- MEM -> FETCH for a store.
- WRITEBACK -> FETCH.
REQ-021 Instruction latency: ALU 4 cycles; store 4 cycles; load 5 cycles; nop 3 cycles.
REQ-022 Write timing: register writes occur only in WRITEBACK; data-memory writes occur only in MEM.
REQ-023 ld_done pulses high for one cycle in the MEM cycle of a load.
REQ-024 Register reads in DECODE observe all writes of earlier instructions.
REQ-025 If enable drops low, the FSM holds its current state and all storage holds.
REQ-026 HALT is left only by reset.
REQ-027 Internal signals, named as follows for waveform debug:
- fsm_state;
- x1, x2, xd: register indices;
- i1, i2, id: indices as decoded;
- y: ALU result;
- y_data: load data;
- wen_regs: register write enable;
- ld_done.

Reset
REQ-028 On rst: fsm_state=IDLE, PC=0, all registers 0, wen_regs=0, ld_done=0, halted=0.
REQ-029 Reset never clears either memory.
REQ-030 A reset asserted mid-instruction aborts the instruction; a pending register or memory write is discarded.

Structure
REQ-031 A shared package holds the state enum, class and op code constants, and field position constants.
REQ-032 Sub-module byte_mem (array memory_bank[0:MEM_BYTES-1] of 8 bits, combinational read, synchronous write) is instantiated twice: instr_cache and data_cache.
REQ-033 The register file instance is named r, with its array named regs.
REQ-034 The load-sequencing logic is instance dt, which exposes load_state.

Verification
REQ-035 Program "mv $10,%gpr0; sdw %gpr0,4(%rzero); mv $11,%gpr0; sdw %gpr0,8(%rzero); ldw 4(%rzero),%gpr1; hlt" -> mem@4=10, mem@8=11, regs[5]=11, regs[6]=10, halted=1.
REQ-036 mv $-1,%gpr2 (imm11=0x7FF) -> regs[7]=0xFFFFFFFF.
REQ-037 mv $10,%rzero -> regs[0] stays 0.
REQ-038 add gpr0(5)+gpr1(7) into gpr2 -> regs[7]=12, reached 4 cycles after the FETCH of the add.
REQ-039 enable held low for 10 cycles mid-program -> fsm_state is frozen and the final results are unchanged.
REQ-040 rst pulsed during the MEM cycle of sdw -> the target word is unchanged, PC=0, and fsm_state=IDLE.
